// File: rtl/cl_axi_pkg.sv
// -----------------------------------------------------------------------------
// cl_axi_pkg
// Shared definitions for the AXI register slice:
//   slice_mode_e   - per-channel slice mode (BYPASS wire-through, FULL skid buffer)
//   RESP_OKAY/RESP_SLVERR - AXI response encodings
//   data_width_ok  - elaboration-time legality check for the data bus width
// -----------------------------------------------------------------------------
package cl_axi_pkg;

    typedef enum logic {
        BYPASS = 1'b0,
        FULL   = 1'b1
    } slice_mode_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Legal data widths are powers of two from 32 to 512 bits.
    function automatic bit data_width_ok(input int w);
        return (w >= 32) && (w <= 512) && ((w & (w - 1)) == 0);
    endfunction

endpackage

// File: rtl/cl_axi_skid_buf.sv
// -----------------------------------------------------------------------------
// cl_axi_skid_buf
// One forward valid/ready channel stage with a single packed payload vector.
//   MODE = BYPASS : valid, ready and payload are wired straight through.
//   MODE = FULL   : 2-entry in-order skid buffer, 1-cycle latency, full rate.
//
// Handshake: a beat moves on a port when valid && ready are both high at the
// rising clock edge. valid never waits for ready, and once valid is raised the
// payload is held until the beat moves.
//
// Ports:
//   i_clk, i_sync_rst          - clock, synchronous active-high reset
//   i_in_valid/o_in_ready      - upstream handshake
//   i_in_data [WIDTH]          - upstream payload
//   o_out_valid/i_out_ready    - downstream handshake
//   o_out_data [WIDTH]         - downstream payload (head entry in FULL mode)
//   o_count [2]                - debug: number of buffered beats (0 in BYPASS)
// -----------------------------------------------------------------------------
module cl_axi_skid_buf
    import cl_axi_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter slice_mode_e MODE  = FULL
) (
    input  logic             i_clk,
    input  logic             i_sync_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic [1:0]       o_count
);

    if (MODE == BYPASS) begin : g_bypass

        logic w_unused_ok;
        assign w_unused_ok = i_clk ^ i_sync_rst;

        assign o_out_valid = i_in_valid;
        assign o_in_ready  = i_out_ready;
        assign o_out_data  = i_in_data;
        assign o_count     = 2'd0;

    end else if (MODE == FULL) begin : g_full

        logic [1:0]       r_count;
        logic             r_ready;
        logic [WIDTH-1:0] r_head;
        logic [WIDTH-1:0] r_skid;
        logic             w_push;
        logic             w_pop;
        logic [1:0]       w_count_nxt;

        // Reset gates the handshake outputs so nothing is offered or accepted
        // for the whole reset interval, not only after the first reset edge.
        assign o_in_ready  = r_ready && !i_sync_rst;
        assign o_out_valid = (r_count != 2'd0) && !i_sync_rst;
        assign o_out_data  = r_head;
        assign o_count     = r_count;

        assign w_push = i_in_valid && o_in_ready;
        assign w_pop  = o_out_valid && i_out_ready;

        always_comb begin
            w_count_nxt = r_count;
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + 2'd1;
                2'b01:   w_count_nxt = r_count - 2'd1;
                default: w_count_nxt = r_count;
            endcase
        end

        // Ready is registered from the next occupancy, so it never depends
        // combinationally on the downstream ready.
        always_ff @(posedge i_clk) begin
            if (i_sync_rst) begin
                r_count <= 2'd0;
                r_ready <= 1'b0;
            end else begin
                r_count <= w_count_nxt;
                r_ready <= (w_count_nxt != 2'd2);
            end
        end

        // Payload storage carries no reset; occupancy alone qualifies it.
        // Push+pop can only happen at count 1 (count 0 has no valid, count 2
        // has no ready), where the incoming beat becomes the new head.
        always_ff @(posedge i_clk) begin
            if (w_push && w_pop) begin
                r_head <= i_in_data;
            end else if (w_push) begin
                if (r_count == 2'd0) begin
                    r_head <= i_in_data;
                end else begin
                    r_skid <= i_in_data;
                end
            end else if (w_pop) begin
                r_head <= r_skid;
            end
        end

    end else begin : g_bad_mode

        $error("cl_axi_skid_buf: illegal MODE value");

    end

endmodule

// File: rtl/cl_axi_reg_slice.sv
// -----------------------------------------------------------------------------
// cl_axi_reg_slice
// AXI4 register slice: five independent forward channels, each either a wire
// (BYPASS) or a 2-entry skid buffer (FULL). Beats are never altered, reordered,
// merged or split.
//
// Ports:
//   clk, sync_rst       - clock, synchronous active-high reset
//   s_aw*, s_w*, s_ar*  - upstream request channels (into the slice)
//   s_b*, s_r*          - upstream response channels (out of the slice)
//   m_aw*, m_w*, m_ar*  - downstream request channels (out of the slice)
//   m_b*, m_r*          - downstream response channels (into the slice)
//   o_dbg_count [10]    - debug occupancy {aw, w, b, ar, r}, 2 bits each
// -----------------------------------------------------------------------------
module cl_axi_reg_slice
    import cl_axi_pkg::*;
#(
    parameter int          DATA_WIDTH = 512,
    parameter int          ADDR_WIDTH = 64,
    parameter int          ID_WIDTH   = 16,
    parameter slice_mode_e AW_MODE    = FULL,
    parameter slice_mode_e W_MODE     = FULL,
    parameter slice_mode_e B_MODE     = FULL,
    parameter slice_mode_e AR_MODE    = FULL,
    parameter slice_mode_e R_MODE     = FULL
) (
    input  logic                    clk,
    input  logic                    sync_rst,

    input  logic [ID_WIDTH-1:0]     s_awid,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [7:0]              s_awlen,
    input  logic [2:0]              s_awsize,
    input  logic                    s_awvalid,
    output logic                    s_awready,

    input  logic [ID_WIDTH-1:0]     s_wid,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wlast,
    input  logic                    s_wvalid,
    output logic                    s_wready,

    output logic [ID_WIDTH-1:0]     s_bid,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,

    input  logic [ID_WIDTH-1:0]     s_arid,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic [7:0]              s_arlen,
    input  logic [2:0]              s_arsize,
    input  logic                    s_arvalid,
    output logic                    s_arready,

    output logic [ID_WIDTH-1:0]     s_rid,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rlast,
    output logic                    s_rvalid,
    input  logic                    s_rready,

    output logic [ID_WIDTH-1:0]     m_awid,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic                    m_awvalid,
    input  logic                    m_awready,

    output logic [ID_WIDTH-1:0]     m_wid,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,

    input  logic [ID_WIDTH-1:0]     m_bid,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,

    output logic [ID_WIDTH-1:0]     m_arid,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    output logic                    m_arvalid,
    input  logic                    m_arready,

    input  logic [ID_WIDTH-1:0]     m_rid,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    input  logic                    m_rvalid,
    output logic                    m_rready,

    output logic [9:0]              o_dbg_count
);

    if (!data_width_ok(DATA_WIDTH)) begin : g_bad_width
        $error("cl_axi_reg_slice: DATA_WIDTH must be a power of two in 32..512");
    end

    localparam int AW_W = ID_WIDTH + ADDR_WIDTH + 8 + 3;
    localparam int W_W  = ID_WIDTH + DATA_WIDTH + DATA_WIDTH / 8 + 1;
    localparam int B_W  = ID_WIDTH + 2;
    localparam int AR_W = ID_WIDTH + ADDR_WIDTH + 8 + 3;
    localparam int R_W  = ID_WIDTH + DATA_WIDTH + 2 + 1;

    logic [AW_W-1:0] w_aw_in, w_aw_out;
    logic [W_W-1:0]  w_w_in,  w_w_out;
    logic [B_W-1:0]  w_b_in,  w_b_out;
    logic [AR_W-1:0] w_ar_in, w_ar_out;
    logic [R_W-1:0]  w_r_in,  w_r_out;
    logic [1:0]      w_aw_count, w_w_count, w_b_count, w_ar_count, w_r_count;

    assign w_aw_in = {s_awid, s_awaddr, s_awlen, s_awsize};
    assign {m_awid, m_awaddr, m_awlen, m_awsize} = w_aw_out;

    assign w_w_in = {s_wid, s_wdata, s_wstrb, s_wlast};
    assign {m_wid, m_wdata, m_wstrb, m_wlast} = w_w_out;

    assign w_b_in = {m_bid, m_bresp};
    assign {s_bid, s_bresp} = w_b_out;

    assign w_ar_in = {s_arid, s_araddr, s_arlen, s_arsize};
    assign {m_arid, m_araddr, m_arlen, m_arsize} = w_ar_out;

    assign w_r_in = {m_rid, m_rdata, m_rresp, m_rlast};
    assign {s_rid, s_rdata, s_rresp, s_rlast} = w_r_out;

    assign o_dbg_count = {w_aw_count, w_w_count, w_b_count, w_ar_count, w_r_count};

    cl_axi_skid_buf #(.WIDTH(AW_W), .MODE(AW_MODE)) u_aw (
        .i_clk       (clk),
        .i_sync_rst  (sync_rst),
        .i_in_valid  (s_awvalid),
        .o_in_ready  (s_awready),
        .i_in_data   (w_aw_in),
        .o_out_valid (m_awvalid),
        .i_out_ready (m_awready),
        .o_out_data  (w_aw_out),
        .o_count     (w_aw_count)
    );

    cl_axi_skid_buf #(.WIDTH(W_W), .MODE(W_MODE)) u_w (
        .i_clk       (clk),
        .i_sync_rst  (sync_rst),
        .i_in_valid  (s_wvalid),
        .o_in_ready  (s_wready),
        .i_in_data   (w_w_in),
        .o_out_valid (m_wvalid),
        .i_out_ready (m_wready),
        .o_out_data  (w_w_out),
        .o_count     (w_w_count)
    );

    cl_axi_skid_buf #(.WIDTH(B_W), .MODE(B_MODE)) u_b (
        .i_clk       (clk),
        .i_sync_rst  (sync_rst),
        .i_in_valid  (m_bvalid),
        .o_in_ready  (m_bready),
        .i_in_data   (w_b_in),
        .o_out_valid (s_bvalid),
        .i_out_ready (s_bready),
        .o_out_data  (w_b_out),
        .o_count     (w_b_count)
    );

    cl_axi_skid_buf #(.WIDTH(AR_W), .MODE(AR_MODE)) u_ar (
        .i_clk       (clk),
        .i_sync_rst  (sync_rst),
        .i_in_valid  (s_arvalid),
        .o_in_ready  (s_arready),
        .i_in_data   (w_ar_in),
        .o_out_valid (m_arvalid),
        .i_out_ready (m_arready),
        .o_out_data  (w_ar_out),
        .o_count     (w_ar_count)
    );

    cl_axi_skid_buf #(.WIDTH(R_W), .MODE(R_MODE)) u_r (
        .i_clk       (clk),
        .i_sync_rst  (sync_rst),
        .i_in_valid  (m_rvalid),
        .o_in_ready  (m_rready),
        .i_in_data   (w_r_in),
        .o_out_valid (s_rvalid),
        .i_out_ready (s_rready),
        .o_out_data  (w_r_out),
        .o_count     (w_r_count)
    );

endmodule

// File: tb/tb_cl_axi_reg_slice.sv
// -----------------------------------------------------------------------------
// tb_cl_axi_reg_slice
// Directed bench: AW in BYPASS, all other channels FULL, 512-bit data.
// Covers reset state, W streaming, R backpressure, B push/pop at count 1,
// AR reset with two buffered beats, and AW bypass behaviour.
// -----------------------------------------------------------------------------
module tb_cl_axi_reg_slice;
  import cl_axi_pkg::*;

  localparam int DW  = 512;
  localparam int ADW = 64;
  localparam int IW  = 16;
  localparam int SW  = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic sync_rst;
  always #5 clk = ~clk;

  logic [IW-1:0]  s_awid, s_wid, s_bid, s_arid, s_rid;
  logic [ADW-1:0] s_awaddr, s_araddr;
  logic [7:0]     s_awlen, s_arlen;
  logic [2:0]     s_awsize, s_arsize;
  logic           s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
  logic [DW-1:0]  s_wdata, s_rdata;
  logic [SW-1:0]  s_wstrb;
  logic [1:0]     s_bresp, s_rresp;
  logic           s_bvalid, s_bready, s_arvalid, s_arready;
  logic           s_rlast, s_rvalid, s_rready;

  logic [IW-1:0]  m_awid, m_wid, m_bid, m_arid, m_rid;
  logic [ADW-1:0] m_awaddr, m_araddr;
  logic [7:0]     m_awlen, m_arlen;
  logic [2:0]     m_awsize, m_arsize;
  logic           m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic [DW-1:0]  m_wdata, m_rdata;
  logic [SW-1:0]  m_wstrb;
  logic [1:0]     m_bresp, m_rresp;
  logic           m_bvalid, m_bready, m_arvalid, m_arready;
  logic           m_rlast, m_rvalid, m_rready;
  logic [9:0]     dbg_count;

  cl_axi_reg_slice #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (ADW),
    .ID_WIDTH   (IW),
    .AW_MODE    (BYPASS),
    .W_MODE     (FULL),
    .B_MODE     (FULL),
    .AR_MODE    (FULL),
    .R_MODE     (FULL)
  ) dut (
    .clk (clk), .sync_rst (sync_rst),
    .s_awid (s_awid), .s_awaddr (s_awaddr), .s_awlen (s_awlen), .s_awsize (s_awsize),
    .s_awvalid (s_awvalid), .s_awready (s_awready),
    .s_wid (s_wid), .s_wdata (s_wdata), .s_wstrb (s_wstrb), .s_wlast (s_wlast),
    .s_wvalid (s_wvalid), .s_wready (s_wready),
    .s_bid (s_bid), .s_bresp (s_bresp), .s_bvalid (s_bvalid), .s_bready (s_bready),
    .s_arid (s_arid), .s_araddr (s_araddr), .s_arlen (s_arlen), .s_arsize (s_arsize),
    .s_arvalid (s_arvalid), .s_arready (s_arready),
    .s_rid (s_rid), .s_rdata (s_rdata), .s_rresp (s_rresp), .s_rlast (s_rlast),
    .s_rvalid (s_rvalid), .s_rready (s_rready),
    .m_awid (m_awid), .m_awaddr (m_awaddr), .m_awlen (m_awlen), .m_awsize (m_awsize),
    .m_awvalid (m_awvalid), .m_awready (m_awready),
    .m_wid (m_wid), .m_wdata (m_wdata), .m_wstrb (m_wstrb), .m_wlast (m_wlast),
    .m_wvalid (m_wvalid), .m_wready (m_wready),
    .m_bid (m_bid), .m_bresp (m_bresp), .m_bvalid (m_bvalid), .m_bready (m_bready),
    .m_arid (m_arid), .m_araddr (m_araddr), .m_arlen (m_arlen), .m_arsize (m_arsize),
    .m_arvalid (m_arvalid), .m_arready (m_arready),
    .m_rid (m_rid), .m_rdata (m_rdata), .m_rresp (m_rresp), .m_rlast (m_rlast),
    .m_rvalid (m_rvalid), .m_rready (m_rready),
    .o_dbg_count (dbg_count)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = 32'hA500_0000 + 32'(i * 16 + k);
    return d;
  endfunction

  function automatic logic [SW-1:0] strb_pat(input int i);
    return {8{8'(i * 3 + 1)}};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awvalid = 1'b0;
    s_wid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0;
    s_bready = 1'b0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arvalid = 1'b0;
    s_rready = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0;
    m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
    m_arready = 1'b0;
    m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_m_wvalid"},  m_wvalid,  0);
    check_val({tag, "_s_bvalid"},  s_bvalid,  0);
    check_val({tag, "_m_arvalid"}, m_arvalid, 0);
    check_val({tag, "_s_rvalid"},  s_rvalid,  0);
    check_val({tag, "_s_wready"},  s_wready,  0);
    check_val({tag, "_m_bready"},  m_bready,  0);
    check_val({tag, "_s_arready"}, s_arready, 0);
    check_val({tag, "_m_rready"},  m_rready,  0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int sent;
    int got;

    idle_inputs();
    sync_rst = 1'b1;
    tick(); tick(); tick();

    // Reset state
    check_reset_outputs("rst");
    check_val("rst_count", dbg_count, 0);
    sync_rst = 1'b0;
    tick();
    check_val("post_rst_s_wready",  s_wready,  1);
    check_val("post_rst_m_bready",  m_bready,  1);
    check_val("post_rst_s_arready", s_arready, 1);
    check_val("post_rst_m_rready",  m_rready,  1);

    // AW bypass: combinational valid, ready and payload
    s_awvalid = 1'b1; s_awid = 16'h0123; s_awaddr = 64'h0000_0001_2345_6780;
    s_awlen = 8'd7; s_awsize = 3'd6; m_awready = 1'b0;
    #1;
    check_val("aw_byp_valid", m_awvalid, 1);
    check_val("aw_byp_addr",  m_awaddr, 64'h0000_0001_2345_6780);
    check_val("aw_byp_id",    m_awid, 16'h0123);
    check_val("aw_byp_len",   m_awlen, 7);
    check_val("aw_byp_ready0", s_awready, 0);
    m_awready = 1'b1;
    #1;
    check_val("aw_byp_ready1", s_awready, 1);
    tick();
    s_awvalid = 1'b0; m_awready = 1'b0;
    #1;
    check_val("aw_byp_valid0", m_awvalid, 0);
    check_val("aw_byp_count", dbg_count[9:8], 0);

    // W streaming: 64 beats, out at +1 clk, no gaps, wlast on beat 64 only
    m_wready = 1'b1;
    exp_q.delete();
    sent = 0; got = 0;
    for (int c = 0; c < 70; c++) begin
      check_val("w_out_valid", m_wvalid, (c >= 1 && c <= 64) ? 1 : 0);
      if (m_wvalid) begin
        if (exp_q.size() == 0) check_val("w_unexpected", 1, 0);
        else check_val("w_data", m_wdata, exp_q.pop_front());
        check_val("w_id",   m_wid,   16'(got + 16'h0100));
        check_val("w_strb", m_wstrb, strb_pat(got));
        check_val("w_last", m_wlast, (got == 63) ? 1 : 0);
        got++;
      end
      if (sent < 64) begin
        s_wvalid = 1'b1; s_wdata = pat(sent); s_wid = 16'(sent + 16'h0100);
        s_wstrb = strb_pat(sent); s_wlast = (sent == 63);
        check_val("w_in_ready", s_wready, 1);
        if (s_wready) begin
          exp_q.push_back(pat(sent));
          sent++;
        end
      end else begin
        s_wvalid = 1'b0; s_wlast = 1'b0;
      end
      tick();
    end
    check_val("w_beats_out", got, 64);
    m_wready = 1'b0;

    // R backpressure: s_rready low for 10 clk, then release
    s_rready = 1'b0;
    exp_q.delete();
    sent = 0; got = 0;
    for (int c = 0; c < 10; c++) begin
      m_rvalid = 1'b1; m_rdata = pat(sent + 100); m_rid = 16'(sent + 16'h0040);
      m_rresp = (sent % 2 == 1) ? RESP_SLVERR : RESP_OKAY; m_rlast = (sent == 5);
      check_val("r_bp_in_ready", m_rready, (c < 2) ? 1 : 0);
      if (m_rready) begin
        exp_q.push_back(pat(sent + 100));
        sent++;
      end
      if (c >= 1) begin
        check_val("r_bp_valid",     s_rvalid, 1);
        check_val("r_bp_hold_data", s_rdata, pat(100));
        check_val("r_bp_hold_id",   s_rid, 16'h0040);
      end
      tick();
    end
    check_val("r_bp_accepted", sent, 2);
    check_val("r_bp_count", dbg_count[1:0], 2);

    s_rready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 0) check_val("r_rel_ready_full", m_rready, 0);
      if (c == 1) check_val("r_rel_ready_after_pop", m_rready, 1);
      if (s_rvalid) begin
        if (exp_q.size() == 0) check_val("r_unexpected", 1, 0);
        else check_val("r_data", s_rdata, exp_q.pop_front());
        check_val("r_id",   s_rid, 16'(got + 16'h0040));
        check_val("r_resp", s_rresp, (got % 2 == 1) ? RESP_SLVERR : RESP_OKAY);
        check_val("r_last", s_rlast, (got == 5) ? 1 : 0);
        got++;
      end
      if (sent < 6) begin
        m_rvalid = 1'b1; m_rdata = pat(sent + 100); m_rid = 16'(sent + 16'h0040);
        m_rresp = (sent % 2 == 1) ? RESP_SLVERR : RESP_OKAY; m_rlast = (sent == 5);
        if (m_rready) begin
          exp_q.push_back(pat(sent + 100));
          sent++;
        end
      end else begin
        m_rvalid = 1'b0; m_rlast = 1'b0;
      end
      tick();
    end
    check_val("r_beats_out", got, 6);
    check_val("r_drained", s_rvalid, 0);
    s_rready = 1'b0;

    // B: simultaneous push/pop at count 1 for 100 clk
    m_bvalid = 1'b1; m_bid = 16'h0200; m_bresp = RESP_OKAY; s_bready = 1'b0;
    check_val("b_first_ready", m_bready, 1);
    tick();
    s_bready = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      check_val("b_pp_valid", s_bvalid, 1);
      check_val("b_pp_id",    s_bid, 16'(16'h0200 + k - 1));
      check_val("b_pp_resp",  s_bresp, ((k - 1) % 2 == 1) ? RESP_SLVERR : RESP_OKAY);
      check_val("b_pp_ready", m_bready, 1);
      check_val("b_pp_count", dbg_count[5:4], 1);
      m_bid = 16'(16'h0200 + k);
      m_bresp = (k % 2 == 1) ? RESP_SLVERR : RESP_OKAY;
      tick();
    end
    m_bvalid = 1'b0;
    check_val("b_last_id", s_bid, 16'h0264);
    tick();
    check_val("b_drained", s_bvalid, 0);
    s_bready = 1'b0;

    // AR: reset with two buffered beats
    m_arready = 1'b0;
    s_arvalid = 1'b1; s_arid = 16'h0300; s_araddr = 64'h1000; s_arlen = 8'd3; s_arsize = 3'd6;
    tick();
    s_arid = 16'h0301; s_araddr = 64'h2000;
    tick();
    s_arvalid = 1'b0;
    check_val("ar_full_ready", s_arready, 0);
    check_val("ar_full_valid", m_arvalid, 1);
    check_val("ar_full_head",  m_arid, 16'h0300);
    check_val("ar_full_count", dbg_count[3:2], 2);
    sync_rst = 1'b1;
    #1;
    check_val("ar_rst_valid_now", m_arvalid, 0);
    check_val("ar_rst_ready_now", s_arready, 0);
    tick();
    check_reset_outputs("ar_rst");
    check_val("ar_rst_count", dbg_count, 0);
    tick();
    sync_rst = 1'b0; m_arready = 1'b1;
    tick();
    check_val("ar_post_ready", s_arready, 1);
    check_val("ar_post_valid", m_arvalid, 0);
    s_arvalid = 1'b1; s_arid = 16'h03AA; s_araddr = 64'hDEAD_BEEF_0000_0040;
    tick();
    s_arvalid = 1'b0;
    check_val("ar_new_valid", m_arvalid, 1);
    check_val("ar_new_id",    m_arid, 16'h03AA);
    check_val("ar_new_addr",  m_araddr, 64'hDEAD_BEEF_0000_0040);
    tick();
    check_val("ar_new_gone", m_arvalid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
